// File: rtl/gated_cnt_pkg.sv
// Shared defaults and direction encoding for the gated counter bank.
package gated_cnt_pkg;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_CHANNELS = 2;
    localparam int DEF_MODULO   = 10;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/clk_gate.sv
// Latch-based integrated clock gate: enable captured while clk is low,
// so the gated clock can only produce whole high pulses.
module clk_gate (
    input  logic clk,
    input  logic en,
    output logic gclk
);

    logic en_latched;

    // NOTE: this latch is intentional; transparent only while clk is low so a
    // change on en during the high phase can never chop or extend a pulse.
    always_latch begin
        if (!clk) begin
            en_latched <= en;
        end
    end

    assign gclk = clk & en_latched;

endmodule

// File: rtl/gated_counter_bank.sv
// Bank of independent modulo up/down counters, each on its own gated clock.
// Define GATED_CNT_SAT_EN to make the counters saturate instead of wrapping.
module gated_counter_bank
    import gated_cnt_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int MODULO   = DEF_MODULO
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       up_dn,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] load_val,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       tc,
    output logic                      active
);

    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MODULO - 1);

    logic [CHANNELS-1:0] gate_en;
    logic [CHANNELS-1:0] tc_next;

    for (genvar i = 0; i < CHANNELS; i++) begin : gen_ch
        logic             gclk;
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] cnt_next;
        logic [WIDTH-1:0] ld_raw;
        logic [WIDTH-1:0] ld_val;
        logic             hit;

        // Reset must open the gate, otherwise a stopped channel would ignore it.
        assign gate_en[i] = enable[i] | load[i] | reset;

        clk_gate u_gate (
            .clk  (clk),
            .en   (gate_en[i]),
            .gclk (gclk)
        );

        assign ld_raw = load_val[i*WIDTH +: WIDTH];
        assign ld_val = (32'(ld_raw) >= MODULO) ? LIMIT : ld_raw;

        always_comb begin
            cnt_next = cnt;
            hit      = 1'b0;
            case (up_dn[i])
`ifdef GATED_CNT_SAT_EN
                DIR_UP: begin
                    if (cnt != LIMIT) begin
                        cnt_next = cnt + 1'b1;
                        hit      = (cnt_next == LIMIT);
                    end
                end
                DIR_DN: begin
                    if (cnt != '0) begin
                        cnt_next = cnt - 1'b1;
                        hit      = (cnt_next == '0);
                    end
                end
`else
                DIR_UP: begin
                    if (cnt == LIMIT) begin
                        cnt_next = '0;
                        hit      = 1'b1;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                DIR_DN: begin
                    if (cnt == '0) begin
                        cnt_next = LIMIT;
                        hit      = 1'b1;
                    end else begin
                        cnt_next = cnt - 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end

        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process evaluation order.
        always_ff @(posedge gclk) begin
            if (reset) begin
                cnt <= '0;
            end else if (load[i]) begin
                cnt <= ld_val;
            end else if (enable[i]) begin
                cnt <= cnt_next;
            end
        end

        // A load on the same edge wins over counting, so it can never flag tc.
        assign tc_next[i] = enable[i] & ~load[i] & ~reset & hit;

        assign count[i*WIDTH +: WIDTH] = cnt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tc     <= '0;
            active <= 1'b0;
        end else begin
            tc     <= tc_next;
            active <= |gate_en;
        end
    end

endmodule

// File: doc/gated_counter_bank.md
GATED_COUNTER_BANK -- requirements
Module: gated_counter_bank

Interface
REQ-001 Parameter WIDTH, default 4: bit width of each channel counter (2..16).
REQ-002 Parameter CHANNELS, default 2: number of independent counter channels (1..8).
REQ-003 Parameter MODULO, default 10: count range 0..MODULO-1; 2 <= MODULO <= 2**WIDTH.
REQ-004 clk  input  1: single clock; all state updates on rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 enable  input  CHANNELS: per-channel count enable; also opens that channel's clock gate.
REQ-007 up_dn  input  CHANNELS: per-channel direction, 1 = up, 0 = down.
REQ-008 load  input  CHANNELS: per-channel synchronous load strobe.
REQ-009 load_val  input  CHANNELS*WIDTH: packed load values; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-010 count  output  CHANNELS*WIDTH: packed counter values, same packing as load_val.
REQ-011 tc  output  CHANNELS: terminal-count pulse, registered, one cycle wide.
REQ-012 active  output  1: registered OR of all channel gate enables from the previous cycle.

Function
REQ-013 Each channel counter SHALL be clocked by its own gated clock; gate enable = enable[i] | load[i] | reset.
REQ-014 Per-channel priority on a gated edge: reset, then load, then count.
REQ-015 Load: count takes load_val; values >= MODULO are clamped to MODULO-1.
REQ-016 Count up: next = count+1, wrapping from MODULO-1 to 0.
REQ-017 Count down: next = count-1, wrapping from 0 to MODULO-1.
REQ-018 tc[i] SHALL assert in the cycle after an edge where channel i wrapped (either direction), and deassert otherwise.
REQ-019 Load never asserts tc, including simultaneous load and enable at a wrap value.
REQ-020 enable[i]=0 and load[i]=0: gated clock stops, count holds, tc[i] returns to 0 next cycle.
REQ-021 tc and active registers SHALL be clocked by the ungated clk.
REQ-022 An up_dn change takes effect on the next enabled edge; no extra latency.
REQ-023 Channels SHALL be fully independent; simultaneous events on different channels do not interact.

Reset
REQ-024 With reset high at an edge: all count = 0, tc = 0, active = 0.
REQ-025 Reset mid-count SHALL take effect at the next edge regardless of enable, because the gate is forced open.
REQ-026 The first enabled edge after reset releases counts from 0.

Configuration
REQ-027 Macro GATED_CNT_SAT_EN defined: counters saturate at MODULO-1 (up) and at 0 (down) instead of wrapping.
REQ-028 Under GATED_CNT_SAT_EN, tc[i] asserts on the edge that first reaches the limit; tc stays 0 while held at the limit.
REQ-029 Macro undefined: wrap behaviour per REQ-016 to REQ-018.

Structure
REQ-030 Package gated_cnt_pkg SHALL hold the default WIDTH/CHANNELS/MODULO constants and the direction encoding constants (DIR_UP = 1, DIR_DN = 0).
REQ-031 Sub-module clk_gate SHALL be a latch-based ICG: enable latched while clk low, gclk = clk AND latched enable; one instance per channel.
REQ-032 Channel logic SHALL be produced by a generate loop over CHANNELS.

Verification (WIDTH=4, CHANNELS=2, MODULO=10)
REQ-033 reset=1 for 2 edges with enable=2'b11 -> count=0/0, tc=0, active=0.
REQ-034 ch0 up, enable 12 edges from 0 -> 1..9,0,1,2; tc[0] high exactly one cycle after the 9->0 edge.
REQ-035 ch1 down from load 3, enable 5 edges -> 2,1,0,9,8; tc[1] one pulse after the 0->9 edge; ch0 unchanged.
REQ-036 load_val=12 on ch0 -> count0=9 with no tc; enable dropped for 3 cycles -> count0 holds 9 and the gated clock shows no edges.
REQ-037 reset asserted with enable=0 while count0=5 -> count0=0 at the next edge.
REQ-038 GATED_CNT_SAT_EN build, ch0 up from 7 for 5 edges -> 8,9,9,9,9; tc[0] one pulse only.
